// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC angle-path sequencer.
//   state_t      : sequencer states IDLE / RUN / DONE
//   MAX_ITER     : depth of the arctangent table
//   ATAN_TABLE   : atan(2^-i) as a 32-bit binary angle, pi = 2^31
//   atan_scaled  : table entry rescaled to a narrower angle width, rounded half-up
package cordic_pkg;

  localparam int unsigned MAX_ITER = 24;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] ATAN_TABLE [0:MAX_ITER-1] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
  };

  // A = (T + 2^(31-width)) >> (32-width); at full width the entry is used as is.
  function automatic logic [31:0] atan_scaled(input int unsigned i, input int unsigned width);
    logic [32:0] sum;
    if (i >= MAX_ITER) return '0;
    if (width >= 32) return ATAN_TABLE[i];
    sum = {1'b0, ATAN_TABLE[i]} + (33'd1 << (31 - width));
    return 32'(sum >> (32 - width));
  endfunction

endpackage

// File: rtl/cordic_angle_seq_if.sv
// Handshake and result bundle of the CORDIC angle-path sequencer.
//   master : requester side (drives start/endangle, observes the rest)
//   slave  : sequencer side
// Signals: start, endangle[WIDTH], busy, done, dir, iter[IW], fold, outreg[WIDTH]
interface cordic_angle_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 16
);
  localparam int unsigned IW = (ITER > 1) ? $clog2(ITER) : 1;

  logic             start;
  logic [WIDTH-1:0] endangle;
  logic             busy;
  logic             done;
  logic             dir;
  logic [IW-1:0]    iter;
  logic             fold;
  logic [WIDTH-1:0] outreg;

  modport master (output start, endangle,
                  input  busy, done, dir, iter, fold, outreg);
  modport slave  (input  start, endangle,
                  output busy, done, dir, iter, fold, outreg);
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: atan_o = atan(2^-idx_i) as a WIDTH-bit
// binary angle (full scale +/-pi), rounded half-up from the 32-bit table.
//   idx_i  : iteration index
//   atan_o : scaled angle increment
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IW    = 4
) (
  input  logic [IW-1:0]    idx_i,
  output logic [WIDTH-1:0] atan_o
);

  always_comb begin
    atan_o = WIDTH'(atan_scaled(32'(idx_i), WIDTH));
  end

endmodule

// File: rtl/cordic_angle_seq.sv
// Angle-path (z) sequencer for an iterative rotation-mode CORDIC. A start in
// IDLE loads the target angle, then ITER micro-rotations each add or subtract
// atan(2^-i) depending on the residual sign. dir/iter drive the companion
// x/y datapath in the same cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus.start/endangle : request and target angle (sampled in IDLE only)
//   bus.busy  : RUN or DONE;  bus.done : one-cycle completion pulse
//   bus.dir   : 1 = residual >= 0 (subtract), valid in RUN, else 0
//   bus.iter  : current iteration index;  bus.outreg : residual angle z
//   bus.fold  : start angle was folded by pi (x/y result must be negated)
// Optional macro CORDIC_QUADRANT_FOLD_EN: fold angles outside [-pi/2, pi/2)
// by pi at load. Undefined: fold is 0 and endangle loads unmodified.
module cordic_angle_seq
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 16
) (
  input  logic              clock,
  input  logic              reset,
  cordic_angle_seq_if.slave bus
);

  localparam int unsigned   IW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IW-1:0] LAST = IW'(ITER - 1);

  state_t           state_q;
  logic [WIDTH-1:0] z_q, z_d;
  logic [IW-1:0]    iter_q;
  logic             busy_q, done_q, fold_q;
  logic [WIDTH-1:0] atan, atan_x;
  logic             pos;
  logic [WIDTH-1:0] load_z;
  logic             load_fold;

  cordic_atan_rom #(.WIDTH(WIDTH), .IW(IW)) u_rom (
    .idx_i  (iter_q),
    .atan_o (atan)
  );

  // Single adder: z + (A ^ {pos}) + pos gives z - A when pos, z + A otherwise.
  always_comb begin
    pos    = ~z_q[WIDTH-1];
    atan_x = atan ^ {WIDTH{pos}};
    z_d    = z_q + atan_x + {{(WIDTH-1){1'b0}}, pos};
  end

  always_comb begin
`ifdef CORDIC_QUADRANT_FOLD_EN
    load_fold = bus.endangle[WIDTH-1] ^ bus.endangle[WIDTH-2];
    load_z    = {bus.endangle[WIDTH-1] ^ load_fold, bus.endangle[WIDTH-2:0]};
`else
    load_fold = 1'b0;
    load_z    = bus.endangle;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      z_q     <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fold_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            z_q     <= load_z;
            fold_q  <= load_fold;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          z_q <= z_d;
          if (iter_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.dir    = (state_q == RUN) & pos;
  assign bus.iter   = iter_q;
  assign bus.fold   = fold_q;
  assign bus.outreg = z_q;

endmodule

// File: tb/tb_cordic_angle_seq.sv
module tb_cordic_angle_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] endangle;

  always #5 clock = ~clock;

  cordic_angle_seq_if #(.WIDTH(16), .ITER(16)) if16 ();
  cordic_angle_seq_if #(.WIDTH(16), .ITER(12)) if12 ();

  assign if16.start    = start;
  assign if16.endangle = endangle;
  assign if12.start    = start;
  assign if12.endangle = endangle;

  cordic_angle_seq #(.WIDTH(16), .ITER(16)) dut16 (.clock(clock), .reset(reset), .bus(if16));
  cordic_angle_seq #(.WIDTH(16), .ITER(12)) dut12 (.clock(clock), .reset(reset), .bus(if12));

  // Index 0 = ITER 16 instance, index 1 = ITER 12 instance.
  logic [1:0]       o_busy, o_done, o_dir, o_fold;
  logic [1:0][3:0]  o_iter;
  logic [1:0][15:0] o_z;
  assign o_busy = {if12.busy, if16.busy};
  assign o_done = {if12.done, if16.done};
  assign o_dir  = {if12.dir,  if16.dir};
  assign o_fold = {if12.fold, if16.fold};
  assign o_iter = {if12.iter, if16.iter};
  assign o_z    = {if12.outreg, if16.outreg};

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: angle increments from real arctangent, residual walk per op.
  logic [15:0] a_ref [0:23];
  logic [15:0] m_z   [0:1][0:24];
  bit          m_d   [0:1][0:23];
  bit          m_fold;

  // Observations of the ITER 16 instance during the latest operation.
  logic [15:0] obs_z    [0:17];
  logic        obs_d    [0:17];
  logic        obs_done [0:17];
  logic        obs_busy [0:17];
  logic        obs_fold;
  logic [15:0] fin_obs  [0:1];

  function automatic int unsigned niter(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  task automatic build_atan();
    real pi;
    pi = 3.14159265358979323846;
    for (int i = 0; i < 24; i++)
      a_ref[i] = 16'($rtoi($floor($atan(1.0 / (2.0 ** i)) / pi * 32768.0 + 0.5)));
  endtask

  task automatic model_all(input logic [15:0] ang);
    logic [15:0] z0;
    z0 = ang;
    m_fold = 1'b0;
`ifdef CORDIC_QUADRANT_FOLD_EN
    if (ang[15] != ang[14]) begin
      z0 = ang - 16'h8000;
      m_fold = 1'b1;
    end
`endif
    for (int d = 0; d < 2; d++) begin
      logic [15:0] zz;
      int unsigned n;
      n  = niter(d);
      zz = z0;
      for (int unsigned i = 0; i < n; i++) begin
        m_z[d][i] = zz;
        m_d[d][i] = ($signed(zz) >= 0);
        zz = m_d[d][i] ? zz - a_ref[i] : zz + a_ref[i];
      end
      m_z[d][n] = zz;
    end
  endtask

  task automatic check_cycle(input int d, input int unsigned c);
    int unsigned n;
    string sfx;
    n   = niter(d);
    sfx = (d == 0) ? "16" : "12";
    chk({"fold", sfx}, 32'(o_fold[d]), 32'(m_fold));
    if (c < n) begin
      chk({"busy", sfx}, 32'(o_busy[d]), 32'd1);
      chk({"done", sfx}, 32'(o_done[d]), 32'd0);
      chk({"dir", sfx},  32'(o_dir[d]),  32'(m_d[d][c]));
      chk({"iter", sfx}, 32'(o_iter[d]), c);
      chk({"z", sfx},    32'(o_z[d]),    32'(m_z[d][c]));
    end else begin
      chk({"busy", sfx}, 32'(o_busy[d]), (c == n) ? 32'd1 : 32'd0);
      chk({"done", sfx}, 32'(o_done[d]), (c == n) ? 32'd1 : 32'd0);
      chk({"dir", sfx},  32'(o_dir[d]),  32'd0);
      chk({"iter", sfx}, 32'(o_iter[d]), n - 1);
      chk({"zfin", sfx}, 32'(o_z[d]),    32'(m_z[d][n]));
      if (c == n) fin_obs[d] = o_z[d];
    end
  endtask

  // Starts an operation and checks both instances every cycle until both are
  // idle again. glitch_c != 0 raises start with another angle in that cycle.
  task automatic run_op(input logic [15:0] ang, input int unsigned glitch_c);
    model_all(ang);
    start    = 1'b1;
    endangle = ang;
    @(posedge clock); #1;
    start    = 1'b0;
    endangle = 16'($urandom);
    for (int unsigned c = 0; c < 18; c++) begin
      if (glitch_c != 0 && c == glitch_c) begin
        start    = 1'b1;
        endangle = 16'h1234;
      end else begin
        start = 1'b0;
      end
      for (int d = 0; d < 2; d++) check_cycle(d, c);
      obs_z[c]    = o_z[0];
      obs_d[c]    = o_dir[0];
      obs_done[c] = o_done[0];
      obs_busy[c] = o_busy[0];
      if (c == 0) obs_fold = o_fold[0];
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  task automatic check_bound(input logic in_range);
    for (int d = 0; d < 2; d++) begin
      int v;
      int unsigned n;
      n = niter(d);
      v = int'($signed(fin_obs[d]));
      if (v < 0) v = -v;
      if (in_range)
        chk((d == 0) ? "bound16" : "bound12",
            32'(v <= int'(a_ref[n-1]) + int'(n)), 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] ang;
    build_atan();
    reset    = 1'b1;
    start    = 1'b0;
    endangle = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_z",    32'(o_z[d]),    32'd0);
      chk("rst_iter", 32'(o_iter[d]), 32'd0);
      chk("rst_busy", 32'(o_busy[d]), 32'd0);
      chk("rst_done", 32'(o_done[d]), 32'd0);
      chk("rst_fold", 32'(o_fold[d]), 32'd0);
      chk("rst_dir",  32'(o_dir[d]),  32'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;

    // 0x2000: first micro-rotations and completion timing
    run_op(16'h2000, 0);
    chk("t1_z0", 32'(obs_z[0]), 32'h2000);
    chk("t1_d0", 32'(obs_d[0]), 32'd1);
    chk("t1_z1", 32'(obs_z[1]), 32'h0000);
    chk("t1_d1", 32'(obs_d[1]), 32'd1);
    chk("t1_z2", 32'(obs_z[2]), 32'hED1C);
    chk("t1_d2", 32'(obs_d[2]), 32'd0);
    chk("t1_z3", 32'(obs_z[3]), 32'hF717);
    chk("t1_done15", 32'(obs_done[15]), 32'd0);
    chk("t1_done16", 32'(obs_done[16]), 32'd1);
    chk("t1_busy17", 32'(obs_busy[17]), 32'd0);
    check_bound(1'b1);

    // 0x0000 back-to-back
    run_op(16'h0000, 0);
    chk("t2_d0", 32'(obs_d[0]), 32'd1);
    chk("t2_z1", 32'(obs_z[1]), 32'hE000);
    chk("t2_d1", 32'(obs_d[1]), 32'd0);
    chk("t2_z2", 32'(obs_z[2]), 32'hF2E4);
    check_bound(1'b1);

    // start raised during RUN (and during DONE of the ITER 12 instance)
    run_op(16'h2000, 3);
    chk("t3_z16", 32'(obs_z[16]), 32'(m_z[0][16]));
    run_op(16'h1800, 12);
    run_op(16'hE800, 0);

    // reset at iteration 5
    start    = 1'b1;
    endangle = 16'h1800;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
    end
    chk("t4_iter5", 32'(o_iter[0]), 32'd5);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("t4_z",    32'(o_z[d]),    32'd0);
      chk("t4_iter", 32'(o_iter[d]), 32'd0);
      chk("t4_busy", 32'(o_busy[d]), 32'd0);
      chk("t4_fold", 32'(o_fold[d]), 32'd0);
    end
    for (int unsigned c = 0; c < 20; c++) begin
      chk("t4_nodone16", 32'(o_done[0]), 32'd0);
      chk("t4_nodone12", 32'(o_done[1]), 32'd0);
      @(posedge clock); #1;
    end
    run_op(16'h1800, 0);
    check_bound(1'b1);

    // quadrant folding
    run_op(16'h6000, 0);
`ifdef CORDIC_QUADRANT_FOLD_EN
    chk("t5_fold", 32'(obs_fold), 32'd1);
    chk("t5_z0",   32'(obs_z[0]), 32'hE000);
    chk("t5_d0",   32'(obs_d[0]), 32'd0);
    chk("t5_z1",   32'(obs_z[1]), 32'h0000);
    check_bound(1'b1);
`else
    chk("t5_fold", 32'(obs_fold), 32'd0);
    chk("t5_z0",   32'(obs_z[0]), 32'h6000);
    chk("t5_d0",   32'(obs_d[0]), 32'd1);
    chk("t5_z1",   32'(obs_z[1]), 32'h4000);
`endif

    // random angles within +/-pi/2
    for (int k = 0; k < 1000; k++) begin
      ang = 16'hC000 + 16'($urandom_range(0, 16'h7FFF));
      run_op(ang, (k % 7 == 0) ? 32'($urandom_range(1, 12)) : 32'd0);
      check_bound(1'b1);
    end

    // random full-range angles: bit-exact always, bound only where defined
    for (int k = 0; k < 200; k++) begin
      ang = 16'($urandom);
      run_op(ang, 0);
`ifdef CORDIC_QUADRANT_FOLD_EN
      check_bound(1'b1);
`else
      check_bound(ang[15] == ang[14]);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
